// File: rtl/cube_pkg.sv
// cube_pkg: shared widths, state encoding and saturation constants for the
// cube reconstruction slice (cube_reconstruct, cube_shift_mult).
package cube_pkg;

    localparam int QW   = 11;  // signed root width
    localparam int RW   = 33;  // signed remainder width
    localparam int DW   = 32;  // signed reconstructed-radicand width
    localparam int SQW  = 21;  // unsigned |q|^2 width
    localparam int CUW  = 31;  // unsigned |q|^3 width
    localparam int SW   = 34;  // signed q^3 + r width before range check
    localparam int ITER = 11;  // shift-add iterations per multiply
    localparam int CNTW = 4;   // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [DW-1:0] DMAX = 32'h7FFF_FFFF;
    localparam logic [DW-1:0] DMIN = 32'h8000_0000;

    // True when the 34-bit sum is representable as a DW-bit signed value,
    // i.e. the top three bits are all copies of the sign.
    function automatic logic fits_dw(input logic [SW-1:0] s);
        return (s[SW-1:DW-1] == {(SW-DW+1){s[SW-1]}});
    endfunction

endpackage

// File: rtl/cube_shift_mult.sv
// cube_shift_mult: iterative unsigned shift-add multiplier, one multiplier
// bit per step, LSB first.
//   clk, rst    : clock, async active-high reset
//   load        : capture a_in/b_in, clear accumulator and counter
//   step        : accumulate a<<cnt if bit cnt of b is set
//   a_in, b_in  : multiplicand (SQW bits) and multiplier (QW bits)
//   prod        : accumulator (final product after ITER steps)
//   prod_next   : accumulator value the current step would produce
//   last        : current step is the final (ITER-th) one
module cube_shift_mult
    import cube_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [SQW-1:0] a_in,
    input  logic [QW-1:0]  b_in,
    output logic [CUW-1:0] prod,
    output logic [CUW-1:0] prod_next,
    output logic           last
);

    logic [CUW-1:0]  a_r;    // multiplicand, pre-shifted by the step count
    logic [QW-1:0]   b_r;    // multiplier, consumed from bit 0 upward
    logic [CUW-1:0]  acc_r;
    logic [CNTW-1:0] cnt_r;
    logic [CUW-1:0]  addend_s;

    // Partial product for the current multiplier bit.
    always_comb begin
        addend_s = '0;
        if (b_r[0]) begin
            addend_s = a_r;
        end else begin
            addend_s = '0;
        end
    end

    assign prod_next = acc_r + addend_s;
    assign prod      = acc_r;
    assign last      = (cnt_r == CNTW'(ITER - 1));

    // Operand shift registers, accumulator and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
            cnt_r <= '0;
        end else if (load) begin
            a_r   <= {{(CUW-SQW){1'b0}}, a_in};
            b_r   <= b_in;
            acc_r <= '0;
            cnt_r <= '0;
        end else if (step) begin
            a_r   <= {a_r[CUW-2:0], 1'b0};
            b_r   <= {1'b0, b_r[QW-1:1]};
            acc_r <= prod_next;
            cnt_r <= cnt_r + 4'd1;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/cube_reconstruct.sv
// cube_reconstruct: rebuilds d = q^3 + r from a cube root q and remainder r
// using one shift-add multiplier twice (|q|*|q|, then sq*|q|).
//   clk, rst : clock, async active-high reset
//   start    : request, sampled only when idle
//   q, r     : signed root (QW) and remainder (RW), captured on accept
//   busy     : high from the cycle after accept until done
//   done     : one-cycle pulse, d/ovf valid from this cycle
//   d        : signed q^3 + r (DW bits), held until the next done
//   ovf      : q^3 + r outside the DW signed range, held with d
// Build option: define CUBE_RECON_SAT_EN to saturate d on overflow instead
// of wrapping.
module cube_reconstruct
    import cube_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] q,
    input  logic [RW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] d,
    output logic          ovf
);

    state_t         state_r;
    logic           sgn_r;
    logic [QW-1:0]  mag_r;
    logic [RW-1:0]  r_r;
    logic           busy_r;
    logic           done_r;
    logic [DW-1:0]  d_r;
    logic           ovf_r;

    logic           load_s;
    logic           step_s;
    logic [SQW-1:0] a_in_s;
    logic [QW-1:0]  b_in_s;
    logic [CUW-1:0] prod_s;
    logic [CUW-1:0] prod_next_s;
    logic           last_s;

    logic [QW-1:0]  abs_q_s;
    logic [SW-1:0]  cu_ext_s;
    logic [SW-1:0]  s_s;
    logic           fits_s;
    logic [DW-1:0]  d_next_s;

    // |q| as unsigned; -1024 maps to 1024 in 11 bits.
    assign abs_q_s = q[QW-1] ? (~q + 11'd1) : q;

    cube_shift_mult u_mult (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .a_in      (a_in_s),
        .b_in      (b_in_s),
        .prod      (prod_s),
        .prod_next (prod_next_s),
        .last      (last_s)
    );

    // Multiplier sequencing. The last SQ step reloads the multiplier with the
    // completed square (prod_next) so CU starts with no bubble cycle.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        a_in_s = '0;
        b_in_s = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                    a_in_s = {{(SQW-QW){1'b0}}, abs_q_s};
                    b_in_s = abs_q_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            SQ: begin
                if (last_s) begin
                    load_s = 1'b1;
                    a_in_s = prod_next_s[SQW-1:0];
                    b_in_s = mag_r;
                end else begin
                    step_s = 1'b1;
                end
            end
            CU: begin
                step_s = 1'b1;
            end
            FIN: begin
                step_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
            end
        endcase
    end

    // Signed sum, range check and output value (wrap or saturate).
    always_comb begin
        cu_ext_s = {{(SW-CUW){1'b0}}, prod_s};
        s_s      = (sgn_r ? (~cu_ext_s + 34'd1) : cu_ext_s) + {r_r[RW-1], r_r};
        fits_s   = fits_dw(s_s);
        d_next_s = s_s[DW-1:0];
`ifdef CUBE_RECON_SAT_EN
        if (!fits_s) begin
            // Overflow with a non-negative sum can only be positive.
            d_next_s = s_s[SW-1] ? DMIN : DMAX;
        end else begin
            d_next_s = s_s[DW-1:0];
        end
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sgn_r   <= 1'b0;
            mag_r   <= '0;
            r_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            d_r     <= '0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sgn_r   <= q[QW-1];
                        mag_r   <= abs_q_s;
                        r_r     <= r;
                        busy_r  <= 1'b1;
                        state_r <= SQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SQ: begin
                    if (last_s) begin
                        state_r <= CU;
                    end else begin
                        state_r <= SQ;
                    end
                end
                CU: begin
                    if (last_s) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= CU;
                    end
                end
                FIN: begin
                    d_r     <= d_next_s;
                    ovf_r   <= ~fits_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_cube_reconstruct.sv
// Self-checking bench for cube_reconstruct: directed cases plus random
// requests compared against a plain-arithmetic model of q^3 + r.
module tb_cube_reconstruct;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] q;
    logic [32:0] r;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    cube_reconstruct dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact q^3 + r, range check, then wrap or saturate to 32 bits.
    task automatic model(input logic signed [10:0] qv, input logic signed [32:0] rv,
                         output logic [31:0] ed, output logic eo);
        longint qq;
        longint e;
        qq = longint'(qv);
        e  = qq * qq * qq + longint'(rv);
        eo = (e > 64'sd2147483647) || (e < -64'sd2147483648);
        ed = e[31:0];
`ifdef CUBE_RECON_SAT_EN
        if (eo) ed = (e > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    endtask

    // One request: accept, wait for done, check latency, busy, d, ovf.
    // intr > 0 pulses a stray start (q=9) that many cycles after accept.
    task automatic do_op(input logic signed [10:0] qv, input logic signed [32:0] rv,
                         input bit hold, input int intr, input string tag);
        logic [31:0] ed;
        logic        eo;
        int          n;
        int          busy_lo;
        model(qv, rv, ed, eo);
        @(negedge clk);
        q     = qv;
        r     = rv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        n       = 0;
        busy_lo = 0;
        while (!done && n < 40) begin
            if (!busy) busy_lo++;
            @(posedge clk);
            #1;
            n++;
            if (!hold && intr > 0) begin
                if (n == intr) begin
                    start = 1'b1;
                    q     = 11'sd9;
                    r     = 33'sd77;
                end else if (n == intr + 1) begin
                    start = 1'b0;
                end
            end
        end
        check({tag, "_latency"}, n, 23);
        check({tag, "_busy_hi"}, busy_lo, 0);
        check({tag, "_busy_at_done"}, longint'(busy), 0);
        check({tag, "_d"}, longint'($signed(d)), longint'($signed(ed)));
        check({tag, "_ovf"}, longint'(ovf), longint'(eo));
        if (!hold) begin
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, longint'(done), 0);
            check({tag, "_d_held"}, longint'($signed(d)), longint'($signed(ed)));
        end
    endtask

    initial begin
        int          seen;
        logic [10:0] rq;
        logic [32:0] rr;
        rst   = 1'b1;
        start = 1'b0;
        q     = '0;
        r     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_d", longint'(d), 0);
        check("rst_ovf", longint'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(-11'sd100, 33'sd0, 1'b0, 0, "neg100");

        // Back-to-back with start held high.
        do_op(11'sd42, 33'sd1278, 1'b1, 0, "b2b_a");
        do_op(11'sd120, 33'sd2482, 1'b1, 0, "b2b_b");
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);

        do_op(-11'sd300, 33'sd0, 1'b0, 0, "neg300");
        do_op(-11'sd231, -33'sd19287, 1'b0, 0, "neg231");
        do_op(-11'sd1, 33'sd0, 1'b0, 0, "neg1");
        do_op(11'sd1023, 33'sd1076884481, 1'b0, 0, "ovf_pos");
        do_op(-11'sd1024, 33'sd0, 1'b0, 0, "neg1024");
        do_op(11'sd0, -33'sd5, 1'b0, 0, "zero_q");

        // Reset in the middle of the CU phase.
        @(negedge clk);
        q     = 11'sd100;
        r     = 33'sd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_d", longint'(d), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        check("midrst_d_zero", longint'(d), 0);
        do_op(11'sd7, 33'sd78, 1'b0, 0, "after_rst");

        // Stray start while busy must be ignored.
        do_op(11'sd55, 33'sd1000, 1'b0, 5, "stray_start");

        // Random requests; half use small remainders, half full-range.
        for (int i = 0; i < 20; i++) begin
            rq = 11'($urandom);
            if (i % 2 == 0) rr = 33'($signed(32'($urandom_range(0, 4000))) - 32'sd2000);
            else rr = {1'($urandom), 32'($urandom)};
            do_op($signed(rq), $signed(rr), 1'b0, 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
